gan_frame_streamer: RTL

GAN_FRAME_STREAMER -- requirements
Module: gan_frame_streamer

---
 rtl/gan_stream_pkg.sv | 27 ++
 rtl/gan_pixel_binariser.sv | 28 ++
 rtl/gan_frame_streamer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gan_stream_pkg.sv
// ---------------------------------------------------------------------------
// gan_stream_pkg
// Constants and types that the GAN streaming blocks share: default frame
// geometry, the frame streamer FSM encoding, and a small index-width helper.
// ---------------------------------------------------------------------------
package gan_stream_pkg;

    // Default frame geometry (28x28 image, 16-bit pixels).
    localparam int GAN_PIXEL_COUNT  = 784;
    localparam int GAN_PIXEL_WIDTH  = 16;
    localparam int FRAME_COUNT_W    = 16;

    // Frame streamer sequencing.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STREAM    = 3'd1,
        ST_WAIT_CORE = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } stream_state_t;

    // Width of a counter that indexes 0..depth-1 (never narrower than 1 bit).
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gan_pixel_binariser.sv
// ---------------------------------------------------------------------------
// gan_pixel_binariser
// Purely combinational reduction of a full frame to one bit per pixel.
//   frame     : PIXEL_COUNT pixels, pixel i at [(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]
//   threshold : unsigned compare value used when mode = 1
//   mode      : 0 -> bit = |pixel ; 1 -> bit = (pixel >= threshold)
//   bin_bits  : bit i is the binarised value of pixel i
// ---------------------------------------------------------------------------
module gan_pixel_binariser
    import gan_stream_pkg::*;
#(
    parameter int PIXEL_COUNT = GAN_PIXEL_COUNT,
    parameter int PIXEL_WIDTH = GAN_PIXEL_WIDTH
) (
    input  logic [PIXEL_WIDTH*PIXEL_COUNT-1:0] frame,
    input  logic [PIXEL_WIDTH-1:0]             threshold,
    input  logic                               mode,
    output logic [PIXEL_COUNT-1:0]             bin_bits
);

    for (genvar i = 0; i < PIXEL_COUNT; i++) begin : g_pixel
        logic [PIXEL_WIDTH-1:0] pix;
        assign pix = frame[(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
        // Both operands are unsigned logic vectors, so threshold 0 gives all ones.
        assign bin_bits[i] = mode ? (pix >= threshold) : (|pix);
    end

endmodule

// File: rtl/gan_frame_streamer.sv
// ---------------------------------------------------------------------------
// gan_frame_streamer
// Accepts whole frames, binarises them on acceptance into one of two
// ping-pong slots, then streams the head slot to the core LANES bits per
// beat, kicks the core and waits for it to finish before the next frame.
//
// Ports
//   clk, rst                         : clock, async active-high reset
//   run_en                           : gate for starting a new frame stream
//   threshold, mode                  : binarisation controls, sampled on accept
//   sample_flat/valid/ready          : frame input handshake
//   pixel_bits/valid/ready           : beat output handshake to core
//   core_frame_ready                 : core holds a full frame
//   core_start                       : one-cycle core start pulse
//   core_done                        : core completion pulse
//   busy                             : high outside IDLE
//   done                             : one-cycle pulse per completed frame
//   frame_count                      : completed frames, wrapping
// ---------------------------------------------------------------------------
module gan_frame_streamer
    import gan_stream_pkg::*;
#(
    parameter int PIXEL_COUNT = GAN_PIXEL_COUNT,
    parameter int PIXEL_WIDTH = GAN_PIXEL_WIDTH,
    parameter int LANES       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run_en,
    input  logic [PIXEL_WIDTH-1:0]             threshold,
    input  logic                               mode,
    input  logic [PIXEL_WIDTH*PIXEL_COUNT-1:0] sample_flat,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    output logic [LANES-1:0]                   pixel_bits,
    output logic                               pixel_bits_valid,
    input  logic                               pixel_bits_ready,
    input  logic                               core_frame_ready,
    output logic                               core_start,
    input  logic                               core_done,
    output logic                               busy,
    output logic                               done,
    output logic [FRAME_COUNT_W-1:0]           frame_count
);

    localparam int BEATS  = PIXEL_COUNT / LANES;
    localparam int BEAT_W = index_width(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (PIXEL_COUNT % LANES != 0) begin : g_lanes_check
        $fatal(1, "gan_frame_streamer: PIXEL_COUNT must be a multiple of LANES");
    end

    // Slot storage: [beat][lane], so a flat binarised frame maps pixel
    // b*LANES+k onto slot_bits[s][b][k] with no reordering.
    logic [BEATS-1:0][LANES-1:0] slot_bits [2];
    logic [1:0]                  slot_valid;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [BEAT_W-1:0]           beat_idx;
    logic [PIXEL_COUNT-1:0]      bin_bits;

    stream_state_t state, next_state;

    logic accept;
    logic beat_fire;
    logic last_beat;
    logic done_set;

    gan_pixel_binariser #(
        .PIXEL_COUNT (PIXEL_COUNT),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_binariser (
        .frame     (sample_flat),
        .threshold (threshold),
        .mode      (mode),
        .bin_bits  (bin_bits)
    );

    // A slot is free whenever both are not valid; readiness depends only on
    // registered state so there is no combinational path from the core side.
    assign sample_ready     = ~(slot_valid[0] & slot_valid[1]);
    assign accept           = sample_valid & sample_ready;
    assign pixel_bits_valid = (state == ST_STREAM);
    assign core_start       = (state == ST_START);
    assign busy             = (state != ST_IDLE);

    // Beat data is a pure mux of stored bits; beat_idx only moves on a
    // handshake, so the output holds steady while the core stalls.
    always_comb begin
        pixel_bits = '0;
        if (state == ST_STREAM) begin
            pixel_bits = slot_bits[rd_ptr][beat_idx];
        end
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        beat_fire  = 1'b0;
        last_beat  = 1'b0;
        done_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (slot_valid[rd_ptr] && run_en) begin
                    next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pixel_bits_ready) begin
                    beat_fire = 1'b1;
                    if (beat_idx == LAST_BEAT) begin
                        last_beat  = 1'b1;
                        next_state = ST_WAIT_CORE;
                    end
                end
            end
            ST_WAIT_CORE: begin
                if (core_frame_ready) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // core_done is only honoured here; elsewhere it is ignored.
                if (core_done) begin
                    done_set   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            slot_valid  <= 2'b00;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            beat_idx    <= '0;
            frame_count <= '0;
            done        <= 1'b0;
        end else begin
            state <= next_state;
            done  <= done_set;

            if (done_set) begin
                frame_count <= frame_count + 1'b1;
            end

            if (beat_fire) begin
                beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
            end

            // Accept and release always touch different slots: a frame is
            // only written into a free slot, and only the valid head is freed.
            if (accept) begin
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= ~wr_ptr;
            end

            if (last_beat) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= ~rd_ptr;
            end
        end
    end

    // NOTE: slot contents are not reset; they are qualified by slot_valid,
    // which is, so the wide storage needs no reset network.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_bits[wr_ptr] <= bin_bits;
        end
    end

endmodule
